block_memory_ctrl: RTL and testbench

- Clocked main-memory stage that sits directly downstream of the 2-way write-back cache.
- Serves the cache's block refills (reads) and dirty-block write-backs (writes).
- Each request moves one 4-word (128-bit) block over a valid/ready request channel and a valid/ready response channel.
- Internally it models a slow DRAM: a programmable access latency, then a word-serial transfer of one 32-bit word per cycle.

---
 rtl/block_memory_ctrl.sv | 109 ++++++++++
 tb/tb_block_memory_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_memory_ctrl.sv
// Block-oriented main-memory controller behind the write-back cache.
// It models a slow DRAM: a programmable wait, then four 32-bit words moved one per cycle.
module block_memory_ctrl #(
    parameter int LATENCY     = 4,
    parameter int DEPTH_WORDS = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [9:0]   req_addr,
    input  logic [127:0] req_wdata,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [127:0] resp_rdata,
    output logic         busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] XFER = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic [3:0] WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    function automatic logic [DEPTH_WORDS-1:0][31:0] init_mem();
        for (int i = 0; i < DEPTH_WORDS; i++) begin
            init_mem[i] = i[31:0];
        end
    endfunction

    // Contents survive reset; each word powers up holding its own index.
    logic [DEPTH_WORDS-1:0][31:0] mem = init_mem();

    logic [1:0]   state_reg;
    logic [3:0]   cnt_reg;
    logic [1:0]   word_reg;
    logic         write_reg;
    logic [5:0]   blk_reg;
    logic [127:0] wdata_reg;
    logic [127:0] rdata_reg;

    logic [7:0]   word_idx;
    logic [31:0]  wr_word;

    assign word_idx = {blk_reg, word_reg};
    assign wr_word  = wdata_reg[{word_reg, 5'd0} +: 32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            word_reg  <= '0;
            write_reg <= 1'b0;
            blk_reg   <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        write_reg <= req_write;
                        blk_reg   <= req_addr[9:4];
                        wdata_reg <= req_wdata;
                        rdata_reg <= '0;
                        word_reg  <= '0;
                        cnt_reg   <= WAIT_INIT;
                        state_reg <= (LATENCY == 0) ? XFER : WAIT;
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd0) begin
                        state_reg <= XFER;
                    end
                end
                XFER: begin
                    if (!write_reg) begin
                        rdata_reg[{word_reg, 5'd0} +: 32] <= mem[word_idx];
                    end
                    word_reg <= word_reg + 2'd1;
                    if (word_reg == 2'd3) begin
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Reset forces IDLE at once, so an interrupted write-back stops after the words already stored.
    always_ff @(posedge clk) begin
        if (state_reg == XFER && write_reg) begin
            mem[word_idx] <= wr_word;
        end
    end

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == RESP);
    assign busy       = (state_reg != IDLE);
    assign resp_rdata = rdata_reg;

endmodule

// File: tb/tb_block_memory_ctrl.sv
// Scoreboarded bench for block_memory_ctrl: issued requests push expected responses,
// an independent monitor pops and compares them as responses appear.
module tb_block_memory_ctrl;

    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid, req_ready, req_write;
    logic [9:0]   req_addr;
    logic [127:0] req_wdata;
    logic         resp_valid, resp_ready;
    logic [127:0] resp_rdata;
    logic         busy;

    logic         z_req_valid, z_req_ready, z_req_write;
    logic [9:0]   z_req_addr;
    logic [127:0] z_req_wdata;
    logic         z_resp_valid, z_resp_ready;
    logic [127:0] z_resp_rdata;
    logic         z_busy;

    always #5 clk = ~clk;

    block_memory_ctrl #(.LATENCY(LAT), .DEPTH_WORDS(256)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .busy(busy)
    );

    block_memory_ctrl #(.LATENCY(0), .DEPTH_WORDS(256)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready), .resp_rdata(z_resp_rdata),
        .busy(z_busy)
    );

    typedef struct {
        logic [127:0] rdata;
        int           acc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [256];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rr_mode = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp_v);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout required event", name);
    endtask

    function automatic logic [127:0] model_block(input logic [5:0] blk);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) begin
            r[k*32 +: 32] = model_mem[blk*4 + k];
        end
        return r;
    endfunction

    // Issue one request; the reference model is updated at issue because transactions are serial.
    task automatic issue(input logic wr, input logic [9:0] addr, input logic [127:0] wd,
                         input bit push, output int acc);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            timeout("req_ready_wait");
            acc = -1;
            return;
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        acc = cyc + 1;
        if (push) begin
            if (wr) begin
                for (int k = 0; k < 4; k++) model_mem[addr[9:4]*4 + k] = wd[k*32 +: 32];
                e.rdata = '0;
            end else begin
                e.rdata = model_block(addr[9:4]);
            end
            e.acc = acc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 10'($urandom);
        req_wdata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        while (!resp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid) timeout("resp_valid_wait");
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) timeout("drain");
    endtask

    initial begin
        forever begin
            @(negedge clk);
            case (rr_mode)
                0:       resp_ready = ($urandom_range(0, 3) != 0);
                1:       resp_ready = 1'b1;
                default: resp_ready = 1'b0;
            endcase
        end
    end

    // Monitor: one pop per rising resp_valid, then stability while the response is held.
    initial begin
        logic         prev_valid;
        logic [127:0] held;
        exp_t         e;
        prev_valid = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (resp_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got response %h required none", resp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_latency", 128'(cyc - e.acc), 128'(LAT + 4));
                    check("busy_in_resp", 128'(busy), 128'(1));
                    $display("resp at cycle %0d: rdata=%h latency=%0d", cyc, resp_rdata, cyc - e.acc);
                end
                held = resp_rdata;
            end else if (resp_valid && prev_valid) begin
                check("resp_hold", resp_rdata, held);
            end
            prev_valid = resp_valid && rst_n;
        end
    end

    initial begin
        int           acc, acc2, nb, g;
        logic         wr;
        logic [5:0]   blk;
        logic [127:0] wd;

        for (int i = 0; i < 256; i++) model_mem[i] = 32'(i);
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0;
        z_resp_ready = 1'b1;
        resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_req_ready", 128'(req_ready), 128'(1));
        check("reset_resp_valid", 128'(resp_valid), 128'(0));
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_resp_rdata", resp_rdata, 128'(0));

        // Refill of block 1 after reset, with busy duration.
        issue(1'b0, 10'h010, '0, 1'b1, acc);
        nb = 0;
        g = 0;
        @(negedge clk);
        while (!resp_valid && g < 100) begin
            if (busy) nb++;
            @(negedge clk);
            g++;
        end
        check("busy_cycles", 128'(nb), 128'(8));
        check("read_0x010", resp_rdata, 128'h00000007_00000006_00000005_00000004);

        // Top block write-back, then read with nonzero low address bits.
        issue(1'b1, 10'h3F0, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 1'b1, acc);
        issue(1'b0, 10'h3FC, '0, 1'b1, acc);
        @(negedge clk);
        wait_resp();
        check("read_0x3FC", resp_rdata, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);

        // Stalled response: a request offered meanwhile must not be taken.
        drain();
        rr_mode = 2;
        issue(1'b0, 10'h050, '0, 1'b1, acc);
        @(negedge clk);
        wait_resp();
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = 10'h050;
            req_wdata = {4{32'hBADC0DE0}};
            check("stall_req_ready", 128'(req_ready), 128'(0));
            check("stall_resp_valid", 128'(resp_valid), 128'(1));
            @(negedge clk);
        end
        req_valid = 1'b0;
        rr_mode = 1;
        drain();
        issue(1'b0, 10'h050, '0, 1'b1, acc);

        // Zero-latency instance.
        drain();
        @(negedge clk);
        z_req_valid = 1'b1;
        z_req_addr  = 10'h000;
        acc = cyc + 1;
        @(posedge clk);
        #1;
        z_req_valid = 1'b0;
        z_req_addr  = 10'h3FF;
        g = 0;
        @(negedge clk);
        while (!z_resp_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("lat0_latency", 128'(cyc - acc), 128'(4));
        check("lat0_rdata", z_resp_rdata, 128'h00000003_00000002_00000001_00000000);

        // Randomized traffic (block 2 kept aside for the abort scenario).
        rr_mode = 0;
        for (int t = 0; t < 40; t++) begin
            wr  = 1'($urandom_range(0, 1));
            blk = 6'($urandom_range(0, 7));
            if (blk == 6'd2) blk = 6'h3F;
            wd  = {$urandom, $urandom, $urandom, $urandom};
            issue(wr, {blk, 4'($urandom)}, wd, 1'b1, acc);
        end

        // Back-to-back refills with the consumer always ready.
        rr_mode = 1;
        drain();
        issue(1'b0, 10'h040, '0, 1'b1, acc);
        issue(1'b0, 10'h060, '0, 1'b1, acc2);
        check("b2b_spacing", 128'(acc2 - acc), 128'(LAT + 6));

        // Write-back to block 2 aborted by reset after two words.
        drain();
        wd = 128'h44444444_33333333_22222222_11111111;
        issue(1'b1, 10'h020, wd, 1'b0, acc);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_req_ready", 128'(req_ready), 128'(1));
        check("abort_resp_valid", 128'(resp_valid), 128'(0));
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_resp_rdata", resp_rdata, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        model_mem[8] = wd[31:0];
        model_mem[9] = wd[63:32];
        issue(1'b0, 10'h020, '0, 1'b1, acc);
        @(negedge clk);
        wait_resp();
        check("abort_read", resp_rdata, 128'h0000000B_0000000A_22222222_11111111);

        drain();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
